// File: rtl/apb_master_bridge.sv
// APB requester bridge: turns single local commands into APB SETUP/ACCESS transfers
// and returns one completion pulse per transfer. A wait-state budget aborts stuck slaves.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d, wait_inc;
  logic              accept, done_ok, done_to;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  assign wait_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d    = StAccess;
        wait_cnt_d = '0;
      end
      StAccess: begin
        // PREADY wins over the budget running out in the same cycle
        if (PREADY) begin
          done_ok = 1'b1;
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == TimeoutCnt) begin
            done_to = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= done_ok || done_to;
      if (accept) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
      end
      if (done_ok) begin
        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
        rsp_err_q     <= PSLVERR;
        rsp_timeout_q <= 1'b0;
      end else if (done_to) begin
        rsp_rdata_q   <= '0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign PSEL        = (state_q != StIdle);
  assign PENABLE     = (state_q == StAccess);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB slave plus command/response scoreboards.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_master_bridge #(
    .ADDR_W (8),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          acc;
  } rsp_t;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
  } cmd_t;

  rsp_t rsp_q[$];
  cmd_t cmd_q[$];

  int total = 0;
  int bad   = 0;

  // slave behaviour: ready after sl_wait stalled ACCESS cycles (>= TIMEOUT means never)
  int          sl_wait  = 0;
  logic [31:0] sl_rdata = 32'h0;
  logic        sl_err   = 1'b0;
  int          s_cnt    = 0;

  int          cyc      = 0;
  int          last_cyc = -1;
  bit          b2b      = 1'b0;
  bit          have_last = 1'b0;
  bit          prev_rsp = 1'b0;
  rsp_t        last_r;
  int          acc_n    = 0;
  logic [7:0]  s_addr;
  logic        s_w;
  logic [31:0] s_d;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  // Bus data outside a ready ACCESS cycle is junk that the bridge must ignore.
  always @(negedge PCLK) begin
    logic rdy;
    if (PSEL && PENABLE) begin
      rdy = (s_cnt == sl_wait);
      s_cnt++;
    end else begin
      rdy   = 1'b0;
      s_cnt = 0;
    end
    PREADY  = rdy;
    PRDATA  = rdy ? sl_rdata : $urandom();
    PSLVERR = rdy ? sl_err : 1'b1;
  end

  always @(negedge PCLK) begin
    cmd_t c;
    rsp_t r;
    if (PENABLE) check_val("psel_with_penable", {63'd0, PSEL}, 64'd1);
    if (PSEL && !PENABLE) begin
      acc_n  = 0;
      s_addr = PADDR;
      s_w    = PWRITE;
      s_d    = PWDATA;
      if (cmd_q.size() == 0) begin
        check_val("unexpected_setup", {63'd0, PSEL}, 64'd0);
      end else begin
        c = cmd_q.pop_front();
        check_val("setup_addr", {56'd0, PADDR}, {56'd0, c.a});
        check_val("setup_write", {63'd0, PWRITE}, {63'd0, c.w});
        if (c.w) check_val("setup_wdata", {32'd0, PWDATA}, {32'd0, c.d});
      end
    end
    if (PSEL && PENABLE) begin
      acc_n++;
      check_val("access_paddr", {56'd0, PADDR}, {56'd0, s_addr});
      check_val("access_pwrite", {63'd0, PWRITE}, {63'd0, s_w});
      check_val("access_pwdata", {32'd0, PWDATA}, {32'd0, s_d});
    end
    if (rsp_valid) begin
      check_val("rsp_one_cycle", {63'd0, prev_rsp}, 64'd0);
      if (rsp_q.size() == 0) begin
        check_val("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
      end else begin
        r = rsp_q.pop_front();
        check_val("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, r.rdata});
        check_val("rsp_err", {63'd0, rsp_err}, {63'd0, r.err});
        check_val("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, r.to});
        check_val("rsp_access_cycles", 64'(acc_n), 64'(r.acc));
        check_val("rsp_while_psel", {63'd0, PENABLE}, 64'd0);
        if (b2b && last_cyc >= 0) check_val("rsp_spacing", 64'(cyc - last_cyc), 64'd3);
        last_cyc  = cyc;
        last_r    = r;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      check_val("hold_rdata", {32'd0, rsp_rdata}, {32'd0, last_r.rdata});
      check_val("hold_err", {63'd0, rsp_err}, {63'd0, last_r.err});
      check_val("hold_timeout", {63'd0, rsp_timeout}, {63'd0, last_r.to});
    end
    prev_rsp = rsp_valid;
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input bit expect_rsp);
    cmd_t c;
    rsp_t r;
    int   n;
    c.w = w;
    c.a = a;
    c.d = d;
    cmd_q.push_back(c);
    if (expect_rsp) begin
      r.to    = (sl_wait >= TIMEOUT);
      r.err   = r.to ? 1'b1 : sl_err;
      r.rdata = (r.to || w) ? 32'h0 : sl_rdata;
      r.acc   = r.to ? TIMEOUT : sl_wait + 1;
      rsp_q.push_back(r);
    end
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) check_val("cmd_accept_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    check_val("drain", 64'(rsp_q.size()), 64'd0);
    repeat (2) @(negedge PCLK);
  endtask

  task automatic one(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input int wt, input logic [31:0] rd, input logic er);
    sl_wait  = wt;
    sl_rdata = rd;
    sl_err   = er;
    send(w, a, d, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h0;
    cmd_wdata = 32'h0;
    PRESETn   = 1'b1;
    #1 PRESETn = 1'b0;
    #1;
    check_val("rst_psel", {63'd0, PSEL}, 64'd0);
    check_val("rst_penable", {63'd0, PENABLE}, 64'd0);
    check_val("rst_pwrite", {63'd0, PWRITE}, 64'd0);
    check_val("rst_paddr", {56'd0, PADDR}, 64'd0);
    check_val("rst_pwdata", {32'd0, PWDATA}, 64'd0);
    check_val("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_val("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check_val("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    check_val("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_val("post_rst_ready", {63'd0, cmd_ready}, 64'd1);

    one(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0BAD_F00D, 1'b0);
    one(1'b0, 8'h24, 32'h0, 3, 32'h12345678, 1'b0);
    one(1'b0, 8'h30, 32'h0, 1, 32'hA5A5_5A5A, 1'b1);
    one(1'b1, 8'h34, 32'h1357_9BDF, 2, 32'h0, 1'b1);
    one(1'b0, 8'h40, 32'h0, 255, 32'hFFFF_FFFF, 1'b0);
    one(1'b0, 8'h44, 32'h0, TIMEOUT - 1, 32'hCAFE_0001, 1'b0);
    one(1'b0, 8'h48, 32'h0, TIMEOUT - 2, 32'hCAFE_0002, 1'b1);

    // back-to-back: each command waits only for cmd_ready, response spacing is 3
    sl_wait  = 0;
    sl_rdata = 32'h55AA_33CC;
    sl_err   = 1'b0;
    b2b      = 1'b1;
    last_cyc = -1;
    send(1'b1, 8'h50, 32'h1111_1111, 1'b1);
    send(1'b1, 8'h54, 32'h2222_2222, 1'b1);
    send(1'b0, 8'h58, 32'h0, 1'b1);
    send(1'b0, 8'h5C, 32'h0, 1'b1);
    drain();
    b2b = 1'b0;

    // reset in the middle of ACCESS abandons the transfer silently
    sl_wait = 255;
    send(1'b0, 8'h60, 32'h0, 1'b0);
    repeat (3) @(negedge PCLK);
    check_val("pre_rst_penable", {63'd0, PENABLE}, 64'd1);
    #2 PRESETn = 1'b0;
    have_last = 1'b0;
    #1;
    check_val("mid_rst_psel", {63'd0, PSEL}, 64'd0);
    check_val("mid_rst_penable", {63'd0, PENABLE}, 64'd0);
    check_val("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_val("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
    check_val("mid_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    repeat (3) @(negedge PCLK);

    for (int i = 0; i < 8; i++) begin
      one(1'($urandom_range(0, 1)), 8'($urandom()), $urandom(), int'($urandom_range(0, 5)),
          $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning PADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles with PREADY=0 before abort (range 1..255).
REQ-004 PCLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  command request from the local side.
REQ-007 cmd_ready  out  1  bridge can accept a command.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_W  transfer address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-013 rsp_err  out  1  slave error or timeout, valid with rsp_valid.
REQ-014 rsp_timeout  out  1  completion caused by timeout, valid with rsp_valid.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB requester controls.
REQ-016 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address and write data.
REQ-017 PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1  APB completer responses.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS; cmd_ready = 1 only in IDLE.
REQ-019 IDLE: cmd_valid&&cmd_ready registers cmd_write/addr/wdata into PWRITE/PADDR/PWDATA; next state SETUP; otherwise stay IDLE.
REQ-020 SETUP: PSEL=1, PENABLE=0; next state ACCESS unconditionally (exactly one cycle).
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA SHALL stay stable from SETUP to end of ACCESS.
REQ-022 ACCESS with PREADY=1: capture PRDATA (reads only; writes give rsp_rdata=0) and PSLVERR; next state IDLE.
REQ-023 rsp_valid SHALL pulse exactly one cycle, the first IDLE cycle after completion; rsp_err=PSLVERR captured, rsp_timeout=0.
REQ-024 Wait counter (8 bits) SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-025 Counter reaching TIMEOUT with PREADY=0 SHALL abort: next state IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 PREADY=1 in the same cycle the counter would reach TIMEOUT SHALL count as normal completion, not timeout.
REQ-027 PSEL=0 and PENABLE=0 in IDLE; PENABLE=1 never without PSEL=1.
REQ-028 A command presented in the same cycle as rsp_valid SHALL be accepted (cmd_ready=1 then); minimum spacing is 3 cycles per transfer.
REQ-029 PSLVERR and PRDATA SHALL be ignored outside ACCESS with PREADY=1.
REQ-030 rsp_rdata, rsp_err, rsp_timeout SHALL hold their value until the next completion.

Reset
REQ-031 PRESETn=0 SHALL immediately force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-032 cmd_ready SHALL be 1 in the first cycle after PRESETn deasserts.
REQ-033 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid.

Verification
REQ-034 Write addr 0x10 data 0xDEADBEEF, PREADY tied 1 -> SETUP cycle, then one ACCESS cycle with PWRITE=1, rsp_valid next cycle, rsp_err=0.
REQ-035 Read addr 0x24, PRDATA=0x12345678, PREADY low 3 ACCESS cycles -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0x12345678.
REQ-036 Read with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
REQ-037 PREADY held 0, TIMEOUT=16 -> 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-038 2 writes then 2 reads issued back-to-back with cmd_valid held 1 -> 4 rsp_valid pulses 3 cycles apart, PSEL never 0 while PENABLE=1.
REQ-039 PRESETn pulsed low mid-ACCESS -> PSEL/PENABLE drop 0 at once, no rsp_valid, cmd_ready=1 after release.
